// File: rtl/p8_modsub_pipe.sv
// p8_modsub_pipe: two-stage modulo (2^WIDTH-1) adder/subtractor with cyclic prefix carry and valid/ready handshake
// Optional build macro: MODSUB_ZERO_NORM_EN (fold the all-ones zero code to 0x00)
module p8_modsub_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic             out_zero
);
   localparam int L = $clog2(WIDTH);

   logic             s1_v, s2_v, s1_adv, s2_adv;
   logic [WIDTH-1:0] s1_g, s1_p, s1_x, b_eff, gc, pc, res, res_n;
   logic             zero_n;

   function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int d);
      return (v << d) | (v >> (WIDTH - d));
   endfunction

   assign b_eff     = in_op ? ~in_b : in_b;
   assign s2_adv    = !s2_v || out_ready;
   assign s1_adv    = !s1_v || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_v;

   // cyclic Kogge-Stone carry network; wrapping the span folds the end-around carry in
   always_comb begin
      gc = s1_g;
      pc = s1_p;
      for (int k = 0; k < L; k++) begin
         gc = gc | (pc & rotl(gc, 1 << k));
         pc = pc & rotl(pc, 1 << k);
      end
      res = s1_x ^ rotl(gc, 1);
   end

`ifdef MODSUB_ZERO_NORM_EN
   // negative zero is folded to 0x00 so only one zero code leaves the block
   always_comb begin
      res_n  = (&res) ? '0 : res;
      zero_n = (res_n == '0);
   end
`else
   // both zero codes pass through and are flagged
   always_comb begin
      res_n  = res;
      zero_n = (res == '0) || (&res);
   end
`endif

   // stage 1: operand capture as generate/propagate/half-sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v <= 1'b0;
         s1_g <= '0;
         s1_p <= '0;
         s1_x <= '0;
      end else if (s1_adv) begin
         s1_v <= in_valid;
         if (in_valid) begin
            s1_g <= in_a & b_eff;
            s1_p <= in_a | b_eff;
            s1_x <= in_a ^ b_eff;
         end
      end
   end

   // stage 2: result register, held while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v     <= 1'b0;
         out_res  <= '0;
         out_zero <= 1'b0;
      end else if (s2_adv) begin
         s2_v <= s1_v;
         if (s1_v) begin
            out_res  <= res_n;
            out_zero <= zero_n;
         end
      end
   end
endmodule

// File: tb/tb_p8_modsub_pipe.sv
// tb_p8_modsub_pipe: vector table, backpressure, reset and random checks of p8_modsub_pipe
module tb_p8_modsub_pipe;
   localparam int W = 8;
   localparam int M = (1 << W) - 1;

   logic         clk = 1'b0, rst_n = 1'b0;
   logic         in_valid = 1'b0, in_op = 1'b0, out_ready = 1'b0;
   logic [W-1:0] in_a = '0, in_b = '0;
   logic         in_ready, out_valid, out_zero;
   logic [W-1:0] out_res;

   int n_cmp = 0, n_bad = 0, n_in = 0, n_out = 0;
   int q[$];
   bit mon_en = 1'b0;

   typedef struct {int a; int b; int op; int res; int z;} vec_t;
   vec_t tv[6];

   p8_modsub_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
      .out_ready(out_ready), .out_res(out_res), .out_zero(out_zero)
   );

   always #5 clk = ~clk;

   // ones-complement arithmetic: a + (op ? ~b : b), wrap any carry out back by subtracting M
   function automatic int exp_res(int a, int b, int op);
      int s;
      s = a + (op != 0 ? M - b : b);
      if (s > M) s -= M;
`ifdef MODSUB_ZERO_NORM_EN
      if (s == M) s = 0;
`endif
      return s;
   endfunction

   task automatic check(string name, int act, int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // transfers happen at the next posedge; sample them half a cycle early
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) check("spurious_out", 1, 0);
            else begin
               int e;
               e = q.pop_front();
               check("stream_res", int'(out_res), e);
               check("stream_zero", int'(out_zero), int'(e == 0 || e == M));
            end
            n_out++;
         end
         if (in_valid && in_ready) begin
            q.push_back(exp_res(int'(in_a), int'(in_b), int'(in_op)));
            n_in++;
         end
      end
   end

   initial begin
      int zc, held;
`ifdef MODSUB_ZERO_NORM_EN
      zc = 0;
`else
      zc = M;
`endif
      tv[0] = '{10, 3, 1, 7, 0};
      tv[1] = '{3, 5, 1, 253, 0};
      tv[2] = '{200, 100, 0, 45, 0};
      tv[3] = '{255, 0, 0, zc, 1};
      tv[4] = '{5, 5, 1, zc, 1};
      tv[5] = '{255, 255, 1, zc, 1};

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_res", int'(out_res), 0);
      check("rst_out_zero", int'(out_zero), 0);
      check("rst_in_ready", int'(in_ready), 1);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         in_a = W'(tv[i].a); in_b = W'(tv[i].b); in_op = tv[i].op[0];
         in_valid = 1'b1; out_ready = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         check("vec_lat1_valid", int'(out_valid), 0);
         @(posedge clk);
         #1;
         check("vec_lat2_valid", int'(out_valid), 1);
         check("vec_res", int'(out_res), tv[i].res);
         check("vec_zero", int'(out_zero), tv[i].z);
         @(posedge clk);
         #1;
         check("vec_single", int'(out_valid), 0);
      end

      mon_en = 1'b1;
      n_in = 0; n_out = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         in_valid = (n_in < 8);
         in_a = W'($urandom); in_b = W'($urandom); in_op = 1'($urandom);
         out_ready = !(c >= 3 && c < 7);
         @(negedge clk);
         if (c == 2) check("bp_in_ready_open", int'(in_ready), 1);
         if (c == 3) begin
            check("bp_in_ready_drop", int'(in_ready), 0);
            held = int'(out_res);
         end
         if (c > 3 && c < 7) begin
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_res", int'(out_res), held);
         end
      end
      check("bp_accepted", n_in, 8);
      check("bp_delivered", n_out, 8);
      check("bp_queue_empty", q.size(), 0);

      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         in_a = W'($urandom); in_b = W'($urandom); in_op = 1'($urandom);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      q.delete();
      n_out = 0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_rst_out_valid", int'(out_valid), 0);
      check("mid_rst_out_res", int'(out_res), 0);
      check("mid_rst_in_ready", int'(in_ready), 1);
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("mid_rst_no_output", n_out, 0);

      n_in = 0; n_out = 0;
      for (int c = 0; c < 10000; c++) begin
         @(posedge clk);
         #1;
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_a = ($urandom_range(0, 7) == 0) ? W'(M) : W'($urandom);
         in_b = ($urandom_range(0, 7) == 0) ? W'(M) : W'($urandom);
         in_op = 1'($urandom);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("rnd_count", n_out, n_in);
      check("rnd_queue_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
